fb_scan_reader: RTL and testbench
=================================

# fb_scan_reader

Raster-order reader for the 1-bit 640x480 framebuffer that the screen-clear and drawing logic writes. It generates VGA horizontal/vertical timing and presents pixel read addresses to the framebuffer RAM. It absorbs the RAM's one-clock read latency and drives pixel data, sync and blank outputs aligned to each other. It sits between the framebuffer read port and the VGA DAC/pins.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk  in  1  system clock
  - reset  in  1  asynchronous reset
- pix_en  in  1  pixel strobe; counters advance only on clk edges where pix_en=1
- rd_x  out  10  framebuffer read column
- rd_y  out  9  framebuffer read row
- rd_en  out  1  framebuffer read strobe
- rd_data  in  1  framebuffer pixel, valid exactly one clk after the cycle in which rd_en=1
- pixel_out  out  1  pixel to DAC (1 = white)
- hsync_n  out  1  horizontal sync, active low
- vsync_n  out  1  vertical sync, active low
- blank_n  out  1  high during the visible region
- frame_start  out  1  one-clk pulse at the start of each frame

## Operation
- Counters:
  - hc: 10 bits, 0..H_TOTAL-1, where H_TOTAL = sum of H_* = 800.
  - vc: 10 bits internally, 0..V_TOTAL-1, where V_TOTAL = 525.
  - On a clk edge with pix_en=1, hc increments. At hc=H_TOTAL-1, hc wraps to 0 and vc increments. At vc=V_TOTAL-1 with that wrap, vc wraps to 0.
  - With pix_en=0 the counters hold.
- Combinational decode of the current (hc,vc):
  - active = hc<H_ACTIVE && vc<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs = V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- Read port:
  - rd_en = active & pix_en.
  - rd_x = active ? hc : 0.
  - rd_y = active ? vc[8:0] : 0.
- Stage 1 registers, loaded every clk: pe_d<=pix_en, act_d<=active, hs_d<=hs, vs_d<=vs.
- Output registers, loaded only when pe_d=1:
  - pixel_out<=act_d & rd_data
  - hsync_n<=~hs_d
  - vsync_n<=~vs_d
  - blank_n<=act_d
- frame_start: registered. High for one clk after an edge where pix_en=1 and (hc,vc)=(H_TOTAL-1,V_TOTAL-1).

## Timing
- Reset values: hc=vc=0, all stage-1 registers 0.
- Reset output values: pixel_out=0, hsync_n=1, vsync_n=1, blank_n=0, frame_start=0.
- rd_x, rd_y and rd_en follow the counters combinationally, so they read 0,0,pix_en under reset.
- Reset asserted mid-frame clears everything immediately. After release the first frame starts at (0,0) with no partial frame.
- Latency: let pix_en=1 at edge N with counters (h,v). rd_en/rd_x/rd_y are presented in the cycle before N, and RAM data is valid after N. The outputs for pixel (h,v) update at edge N+1, i.e. 2 clk after the address is presented.
- sync, blank and pixel always change on the same edge; no relative skew.
- pix_en may be 1 every clk or any sparser pattern. Outputs change only at edges following a pix_en cycle.
- Outside the active region, pixel_out=0 regardless of rd_data.

## Structure
- Shared package vga_pkg holds:
  - localparams H_TOTAL and V_TOTAL, plus the derived sync start/end values for the default timing
  - the framebuffer dimension constants, which the screen-clear and drawing logic also uses
- Sub-module fb_scan_counter holds the hc/vc counters with wrap and the frame-end flag. fb_scan_reader adds the decode, the two-stage pipeline and frame_start.

## Test plan
1. Reset held, then asserted again mid-line at hc≈300:
   - pixel_out=0, hsync_n=1, vsync_n=1, blank_n=0, frame_start=0 immediately.
   - rd_x=0 and rd_y=0 on the first pix_en after release.
2. pix_en=1 every clk, rd_data tied 1:
   - blank_n high for exactly 640 consecutive clk per line, on exactly 480 lines per frame.
   - pixel_out equals blank_n throughout.
3. pix_en=1 every clk, sync check:
   - hsync_n low for exactly 96 clk, beginning 2 clk after rd_x would read 656.
   - vsync_n low for exactly 2 lines (vc 490-491).
   - Line period 800 clk, frame period 420000 clk.
4. pix_en every other clk; bench RAM model returns rd_data=rd_x[0] one clk after rd_en:
   - pixel_out alternates 0,1,0,1 across each visible line.
   - Each value appears on the clk after the pe_d edge, aligned with blank_n.
5. pix_en forced 0 for 10 clk at hc=320:
   - rd_x stays 320.
   - pixel_out, hsync_n, vsync_n and blank_n hold.
   - Resuming continues at 321 with no skipped or duplicated pixel.
6. pix_en=1 every clk across two frames:
   - frame_start high exactly one clk, 420000 clk apart.
   - Each pulse follows the edge at (799,524).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing and framebuffer geometry for the scan-out and drawing logic.
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int HS_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int HS_END   = HS_START + H_SYNC_DEF;
  localparam int VS_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int VS_END   = VS_START + V_SYNC_DEF;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int FB_X_W    = 10;
  localparam int FB_Y_W    = 9;
  localparam int CNT_W     = 10;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } scan_dec_t;

  // Half-open window test lo <= c < hi on a counter value.
  function automatic logic in_window(logic [CNT_W-1:0] c, int lo, int hi);
    return (c >= CNT_W'(lo)) && (c < CNT_W'(hi));
  endfunction
endpackage

// File: rtl/fb_scan_counter.sv
// Horizontal/vertical raster counters advancing on the pixel strobe.
// frame_end_o flags the last pixel of the frame (combinational on the counters).
module fb_scan_counter
  import vga_pkg::*;
#(
  parameter int HTOT = H_TOTAL,
  parameter int VTOT = V_TOTAL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en_i,
  output logic [CNT_W-1:0] hc_o,
  output logic [CNT_W-1:0] vc_o,
  output logic             frame_end_o
);
  logic [CNT_W-1:0] hc_q, hc_d;
  logic [CNT_W-1:0] vc_q, vc_d;
  logic             h_last, v_last;

  assign h_last = (hc_q == CNT_W'(HTOT - 1));
  assign v_last = (vc_q == CNT_W'(VTOT - 1));

  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (pix_en_i) begin
      if (h_last) begin
        hc_d = '0;
        vc_d = v_last ? '0 : vc_q + 1'b1;
      end else begin
        hc_d = hc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q <= '0;
      vc_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
    end
  end

  assign hc_o        = hc_q;
  assign vc_o        = vc_q;
  assign frame_end_o = h_last & v_last;
endmodule

// File: rtl/fb_scan_reader.sv
// Raster-order framebuffer reader: presents read addresses from the scan counters and
// re-aligns sync/blank with the one-clock RAM data so all outputs move on the same edge.
module fb_scan_reader
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  output logic [FB_X_W-1:0] rd_x,
  output logic [FB_Y_W-1:0] rd_y,
  output logic              rd_en,
  input  logic              rd_data,
  output logic              pixel_out,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              blank_n,
  output logic              frame_start
);
  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_S  = H_ACTIVE + H_FP;
  localparam int HS_E  = HS_S + H_SYNC;
  localparam int VS_S  = V_ACTIVE + V_FP;
  localparam int VS_E  = VS_S + V_SYNC;

  logic [CNT_W-1:0] hc, vc;
  logic             frame_end;
  scan_dec_t        dec;

  fb_scan_counter #(
    .HTOT(H_TOT),
    .VTOT(V_TOT)
  ) u_cnt (
    .clk        (clk),
    .reset      (reset),
    .pix_en_i   (pix_en),
    .hc_o       (hc),
    .vc_o       (vc),
    .frame_end_o(frame_end)
  );

  always_comb begin
    dec.active = (hc < CNT_W'(H_ACTIVE)) && (vc < CNT_W'(V_ACTIVE));
    dec.hs     = in_window(hc, HS_S, HS_E);
    dec.vs     = in_window(vc, VS_S, VS_E);
  end

  assign rd_en = dec.active & pix_en;
  assign rd_x  = dec.active ? hc : '0;
  assign rd_y  = dec.active ? vc[FB_Y_W-1:0] : '0;

  logic      pe_q;
  scan_dec_t dec_q;
  logic      pix_q, hsn_q, vsn_q, bn_q, fs_q;

  // Stage 1 tracks the address cycle; stage 2 loads only when that cycle was a pixel
  // strobe, which is exactly when rd_data carries that pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pe_q  <= 1'b0;
      dec_q <= '0;
      pix_q <= 1'b0;
      hsn_q <= 1'b1;
      vsn_q <= 1'b1;
      bn_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      pe_q  <= pix_en;
      dec_q <= dec;
      fs_q  <= pix_en & frame_end;
      if (pe_q) begin
        pix_q <= dec_q.active & rd_data;
        hsn_q <= ~dec_q.hs;
        vsn_q <= ~dec_q.vs;
        bn_q  <= dec_q.active;
      end
    end
  end

  assign pixel_out   = pix_q;
  assign hsync_n     = hsn_q;
  assign vsync_n     = vsn_q;
  assign blank_n     = bn_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_fb_scan_reader.sv
// Bench for fb_scan_reader on a shrunken raster, checked against a pixel-count reference model.
module tb_fb_scan_reader;
  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0, reset = 1'b0, pix_en = 1'b0, rd_data = 1'b0;
  logic [9:0] rd_x;
  logic [8:0] rd_y;
  logic       rd_en, pixel_out, hsync_n, vsync_n, blank_n, frame_start;

  always #5 clk = ~clk;

  fb_scan_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .rd_x(rd_x), .rd_y(rd_y), .rd_en(rd_en), .rd_data(rd_data),
    .pixel_out(pixel_out), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .blank_n(blank_n), .frame_start(frame_start)
  );

  bit fb [VA][HA];
  int errors = 0, checks = 0;
  int n = 0, cyc = 0;
  bit pend_vld, pend_dat;
  int pend_h, pend_v;
  bit e_pix, e_hsn, e_vsn, e_bn, e_fs;
  bit cap_en;
  int cap_x, cap_y;

  typedef struct {
    bit pe;
    bit en;
    int x;
    int y;
    bit bn;
  } vec_t;
  vec_t tbl[6];

  function automatic bit is_act(int h, int v);
    return (h < HA) && (v < VA);
  endfunction
  function automatic bit in_hs(int h);
    return (h >= HA + HFP) && (h < HA + HFP + HS);
  endfunction
  function automatic bit in_vs(int v);
    return (v >= VA + VFP) && (v < VA + VFP + VS);
  endfunction
  function automatic bit fb_at(int x, int y);
    if (x >= 0 && x < HA && y >= 0 && y < VA) return fb[y][x];
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic fill_fb(input int mode);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        fb[y][x] = (mode == 0) ? 1'($urandom) : (mode == 1) ? 1'b1 : 1'(x % 2);
  endtask

  // One clock: drive strobe, check address, advance the model, check outputs.
  task automatic step(input bit pe);
    int h, v;
    h = n % HT;
    v = (n / HT) % VT;
    @(negedge clk);
    pix_en = pe;
    #1;
    chk("rd_en", rd_en, is_act(h, v) && pe);
    chk("rd_x", rd_x, is_act(h, v) ? h : 0);
    chk("rd_y", rd_y, is_act(h, v) ? v : 0);
    cap_en = rd_en;
    cap_x  = rd_x;
    cap_y  = rd_y;
    @(posedge clk);
    if (pend_vld) begin
      e_bn  = is_act(pend_h, pend_v);
      e_pix = e_bn & pend_dat;
      e_hsn = !in_hs(pend_h);
      e_vsn = !in_vs(pend_v);
    end
    e_fs     = pe && (h == HT - 1) && (v == VT - 1);
    pend_vld = pe;
    pend_h   = h;
    pend_v   = v;
    pend_dat = fb_at(h, v);
    if (pe) n++;
    #1;
    rd_data = cap_en ? fb_at(cap_x, cap_y) : 1'($urandom);
    cyc++;
    chk("pixel_out", pixel_out, e_pix);
    chk("hsync_n", hsync_n, e_hsn);
    chk("vsync_n", vsync_n, e_vsn);
    chk("blank_n", blank_n, e_bn);
    chk("frame_start", frame_start, e_fs);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_hsync_n", hsync_n, 1);
    chk("rst_vsync_n", vsync_n, 1);
    chk("rst_blank_n", blank_n, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_rd_x", rd_x, 0);
    chk("rst_rd_y", rd_y, 0);
    pix_en = 1'b1;
    #1;
    chk("rst_rd_en_follows", rd_en, 1);
    pix_en = 1'b0;
    #1;
    chk("rst_rd_en_low", rd_en, 0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    n        = 0;
    pend_vld = 1'b0;
    e_pix = 1'b0; e_hsn = 1'b1; e_vsn = 1'b1; e_bn = 1'b0; e_fs = 1'b0;
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int fs_seen, fs_t0, fs_t1, bn_cnt, hs_cnt, vs_cnt;
    logic [3:0] snap;

    tbl[0] = '{pe: 1'b1, en: 1'b1, x: 0, y: 0, bn: 1'b0};
    tbl[1] = '{pe: 1'b1, en: 1'b1, x: 1, y: 0, bn: 1'b1};
    tbl[2] = '{pe: 1'b0, en: 1'b0, x: 2, y: 0, bn: 1'b1};
    tbl[3] = '{pe: 1'b0, en: 1'b0, x: 2, y: 0, bn: 1'b1};
    tbl[4] = '{pe: 1'b1, en: 1'b1, x: 2, y: 0, bn: 1'b1};
    tbl[5] = '{pe: 1'b1, en: 1'b1, x: 3, y: 0, bn: 1'b1};

    fill_fb(0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].pe);
      chk("tbl_rd_en", cap_en, tbl[i].en);
      chk("tbl_rd_x", cap_x, tbl[i].x);
      chk("tbl_rd_y", cap_y, tbl[i].y);
      chk("tbl_blank_n", blank_n, tbl[i].bn);
    end

    for (int i = 0; i < 900; i++) step(1'($urandom_range(0, 1)));

    // Reset mid-line, then the first strobe must address (0,0).
    for (int k = 0; k < HT + 2 && (n % HT) != 10; k++) step(1'b1);
    do_reset();
    step(1'b1);
    chk("post_rst_rd_x", cap_x, 0);
    chk("post_rst_rd_y", cap_y, 0);

    // Full-rate frames with an all-white buffer; aggregate timing over one frame period.
    fill_fb(1);
    do_reset();
    fs_seen = 0; fs_t0 = 0; fs_t1 = 0; bn_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      step(1'b1);
      chk("pix_eq_blank", pixel_out, blank_n);
      if (fs_seen == 1) begin
        bn_cnt += int'(blank_n);
        hs_cnt += int'(!hsync_n);
        vs_cnt += int'(!vsync_n);
      end
      if (frame_start) begin
        if (fs_seen == 0) fs_t0 = cyc;
        if (fs_seen == 1) fs_t1 = cyc;
        fs_seen++;
      end
    end
    chk("fs_pulses", fs_seen, 2);
    chk("fs_period", fs_t1 - fs_t0, FRAME);
    chk("blank_cycles", bn_cnt, HA * VA);
    chk("hsync_cycles", hs_cnt, HS * VT);
    chk("vsync_cycles", vs_cnt, VS * HT);

    // Every-other-clock strobe with a column-parity buffer.
    fill_fb(2);
    for (int i = 0; i < 2 * FRAME; i++) step(1'(i % 2));

    // Stall mid-line: address and outputs freeze, then resume without slip.
    fill_fb(0);
    for (int k = 0; k < HT + 2 && (n % HT) != 10; k++) step(1'b1);
    step(1'b0);
    chk("pause_rd_x_first", cap_x, 10);
    snap = {pixel_out, hsync_n, vsync_n, blank_n};
    for (int i = 0; i < 9; i++) begin
      step(1'b0);
      chk("pause_rd_x", cap_x, 10);
      chk("pause_hold", {pixel_out, hsync_n, vsync_n, blank_n}, snap);
    end
    step(1'b1);
    chk("resume_rd_x", cap_x, 10);
    step(1'b1);
    chk("resume_next_x", cap_x, 11);
    for (int i = 0; i < 40; i++) step(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
